sram_like_arbiter: RTL and testbench

//  Arbitrates N_CH sram-like masters (ch0 = inst fetch, ch1 = data access) onto one sram-like slave port.

---
 rtl/sram_like_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Merges N_CH sram-like masters onto one sram-like slave port. An id FIFO records
// the channel of each accepted request so that in-order responses go back to it.
//   state  | meaning
//   IDLE   | arbitrate among requesting channels each cycle
//   LOCKED | slave stalled a request; keep presenting lock_id until accepted or dropped
module sram_like_arbiter #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST  = 4,
  parameter int RR     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          m_req,
  input  logic [N_CH-1:0]          m_wr,
  input  logic [2*N_CH-1:0]        m_size,
  input  logic [DATA_W/8*N_CH-1:0] m_wstrb,
  input  logic [ADDR_W*N_CH-1:0]   m_addr,
  input  logic [DATA_W*N_CH-1:0]   m_wdata,
  output logic [N_CH-1:0]          m_addr_ok,
  output logic [N_CH-1:0]          m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [DATA_W/8-1:0]      s_wstrb,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic [$clog2(OUTST):0]   outst_cnt,
  output logic                     err
);

  localparam int ID_W  = $clog2(N_CH);
  localparam int SW    = DATA_W / 8;
  localparam int PTR_W = $clog2(OUTST);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   lock_id_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_d;
  logic [ID_W-1:0]   arb_id;
  logic [ID_W-1:0]   arb_cand;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   head_id;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic [ID_W-1:0]   id_mem_q [OUTST];
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  int                arb_idx;

  logic [ADDR_W-1:0] addr_a  [N_CH];
  logic [DATA_W-1:0] wdata_a [N_CH];
  logic [SW-1:0]     wstrb_a [N_CH];
  logic [1:0]        size_a  [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    assign addr_a[c]    = m_addr[c*ADDR_W +: ADDR_W];
    assign wdata_a[c]   = m_wdata[c*DATA_W +: DATA_W];
    assign wstrb_a[c]   = m_wstrb[c*SW +: SW];
    assign size_a[c]    = m_size[c*2 +: 2];
    assign m_addr_ok[c] = push && (gnt_id == ID_W'(c));
    assign m_data_ok[c] = pop && (head_id == ID_W'(c));
  end

  // Scan from the highest offset down so the nearest requester (from rr_ptr, or index 0) wins.
  always_comb begin
    arb_id   = '0;
    arb_cand = '0;
    arb_idx  = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      arb_idx = (RR != 0) ? int'(rr_ptr_q) + k : k;
      if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
      arb_cand = ID_W'(arb_idx);
      if (m_req[arb_cand]) arb_id = arb_cand;
    end
  end

  assign gnt_id  = (state_q == LOCKED) ? lock_id_q : arb_id;
  assign head_id = id_mem_q[rd_ptr_q];
  assign full    = (cnt_q == CNT_W'(OUTST));
  assign empty   = (cnt_q == '0);

  // Full blocks requests even when a response frees a slot this cycle.
  assign s_req   = !reset && !full &&
                   ((state_q == LOCKED) ? m_req[lock_id_q] : (|m_req));
  assign push    = s_req && s_addr_ok;
  assign pop     = !reset && s_data_ok && !empty;
  assign cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign rr_d    = (gnt_id == ID_W'(N_CH - 1)) ? '0 : gnt_id + 1'b1;

  assign s_wr      = m_wr[gnt_id];
  assign s_size    = size_a[gnt_id];
  assign s_wstrb   = wstrb_a[gnt_id];
  assign s_addr    = addr_a[gnt_id];
  assign s_wdata   = wdata_a[gnt_id];
  assign m_rdata   = s_rdata;
  assign outst_cnt = cnt_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (s_data_ok && empty) err_q <= 1'b1;
      if (push && (RR != 0)) rr_ptr_q <= rr_d;
      case (state_q)
        IDLE: begin
          if (s_req && !s_addr_ok) begin
            state_q   <= LOCKED;
            lock_id_q <= arb_id;
          end
        end
        LOCKED: begin
          if (push || !m_req[lock_id_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= gnt_id;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same directed vectors and
// checks both every cycle against a transaction-level model, plus literal spot checks.
module tb_sram_like_arbiter;
  localparam int N_CH   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OUTST  = 4;
  localparam int SW     = DATA_W / 8;
  localparam int CW     = $clog2(OUTST) + 1;

  logic clk;
  logic reset;
  logic [N_CH-1:0]        m_req;
  logic [N_CH-1:0]        m_wr;
  logic [2*N_CH-1:0]      m_size;
  logic [SW*N_CH-1:0]     m_wstrb;
  logic [ADDR_W*N_CH-1:0] m_addr;
  logic [DATA_W*N_CH-1:0] m_wdata;
  logic                   s_addr_ok;
  logic                   s_data_ok;
  logic [DATA_W-1:0]      s_rdata;

  logic [N_CH-1:0]   aok_o    [2];
  logic [N_CH-1:0]   dok_o    [2];
  logic [DATA_W-1:0] rdata_o  [2];
  logic              sreq_o   [2];
  logic              swr_o    [2];
  logic [1:0]        ssize_o  [2];
  logic [SW-1:0]     sstrb_o  [2];
  logic [ADDR_W-1:0] saddr_o  [2];
  logic [DATA_W-1:0] swdata_o [2];
  logic [CW-1:0]     cnt_o    [2];
  logic              err_o    [2];

  sram_like_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST(OUTST), .RR(1)) u_rr (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(aok_o[0]), .m_data_ok(dok_o[0]),
    .m_rdata(rdata_o[0]), .s_req(sreq_o[0]), .s_wr(swr_o[0]), .s_size(ssize_o[0]),
    .s_wstrb(sstrb_o[0]), .s_addr(saddr_o[0]), .s_wdata(swdata_o[0]), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outst_cnt(cnt_o[0]), .err(err_o[0]));

  sram_like_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST(OUTST), .RR(0)) u_fp (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(aok_o[1]), .m_data_ok(dok_o[1]),
    .m_rdata(rdata_o[1]), .s_req(sreq_o[1]), .s_wr(swr_o[1]), .s_size(ssize_o[1]),
    .s_wstrb(sstrb_o[1]), .s_addr(saddr_o[1]), .s_wdata(swdata_o[1]), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outst_cnt(cnt_o[1]), .err(err_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;
  logic [31:0] cyc;

  // Model: list of outstanding channel ids (oldest first), pending stalled channel, rotation start.
  int ol [2][OUTST];
  int on [2];
  int pend [2];
  int ptr [2];
  bit merr [2];
  bit x_sreq [2];
  bit x_hs [2];
  bit x_pop [2];
  bit x_eset [2];
  int x_ch [2];

  logic [N_CH-1:0]   l_aok  [2];
  logic [N_CH-1:0]   l_dok  [2];
  logic              l_sreq [2];
  logic [ADDR_W-1:0] l_saddr [2];
  logic [CW-1:0]     l_cnt  [2];
  logic              l_err  [2];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic bit req_bit(input int c);
    return 1'(m_req >> c);
  endfunction

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      bit full;
      bit sreq;
      int ch;
      logic [N_CH-1:0] e_aok;
      logic [N_CH-1:0] e_dok;
      full = 1'b0;
      sreq = 1'b0;
      ch = -1;
      e_aok = '0;
      e_dok = '0;
      if (!reset) begin
        full = (on[d] >= OUTST);
        if (pend[d] >= 0) begin
          ch = pend[d];
          sreq = req_bit(ch) && !full;
        end else if (m_req != '0 && !full) begin
          sreq = 1'b1;
          for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (d == 0) ? (ptr[d] + k) % N_CH : k;
            if (ch < 0 && req_bit(c)) ch = c;
          end
        end
        if (sreq && s_addr_ok) e_aok = N_CH'(1) << ch;
        if (s_data_ok && on[d] > 0) e_dok = N_CH'(1) << ol[d][0];
      end
      chk("s_req", d, 64'(sreq_o[d]), 64'(sreq));
      chk("m_addr_ok", d, 64'(aok_o[d]), 64'(e_aok));
      chk("m_data_ok", d, 64'(dok_o[d]), 64'(e_dok));
      chk("outst_cnt", d, 64'(cnt_o[d]), 64'(on[d]));
      chk("err", d, 64'(err_o[d]), 64'(merr[d]));
      chk("m_rdata", d, 64'(rdata_o[d]), 64'(s_rdata));
      if (sreq) begin
        chk("s_addr", d, 64'(saddr_o[d]), 64'(ADDR_W'(m_addr >> (ch * ADDR_W))));
        chk("s_wdata", d, 64'(swdata_o[d]), 64'(DATA_W'(m_wdata >> (ch * DATA_W))));
        chk("s_wr", d, 64'(swr_o[d]), 64'(1'(m_wr >> ch)));
        chk("s_size", d, 64'(ssize_o[d]), 64'(2'(m_size >> (2 * ch))));
        chk("s_wstrb", d, 64'(sstrb_o[d]), 64'(SW'(m_wstrb >> (SW * ch))));
      end
      x_sreq[d] = sreq;
      x_ch[d]   = ch;
      x_hs[d]   = sreq && s_addr_ok;
      x_pop[d]  = !reset && s_data_ok && on[d] > 0;
      x_eset[d] = !reset && s_data_ok && on[d] == 0;
      l_aok[d]   = aok_o[d];
      l_dok[d]   = dok_o[d];
      l_sreq[d]  = sreq_o[d];
      l_saddr[d] = saddr_o[d];
      l_cnt[d]   = cnt_o[d];
      l_err[d]   = err_o[d];
    end
  endtask

  task automatic update();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        on[d] = 0;
        pend[d] = -1;
        ptr[d] = 0;
        merr[d] = 1'b0;
      end else begin
        if (x_pop[d]) begin
          for (int i = 0; i < OUTST - 1; i++) ol[d][i] = ol[d][i+1];
          on[d]--;
        end
        if (x_hs[d]) begin
          ol[d][on[d]] = x_ch[d];
          on[d]++;
        end
        if (x_eset[d]) merr[d] = 1'b1;
        if (pend[d] >= 0) begin
          if (x_hs[d] || !req_bit(pend[d])) pend[d] = -1;
        end else if (x_sreq[d] && !s_addr_ok) begin
          pend[d] = x_ch[d];
        end
        if (x_hs[d] && d == 0) ptr[d] = (x_ch[d] + 1) % N_CH;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [N_CH-1:0] req, input bit aok, input bit dok);
    reset     = rst;
    m_req     = req;
    s_addr_ok = aok;
    s_data_ok = dok;
    m_addr    = {32'hB000_0000 + cyc, 32'hA000_0000 + cyc};
    m_wdata   = {32'h5500_0000 + cyc, 32'h3300_0000 + cyc};
    m_wr      = 2'(cyc);
    m_size    = 4'b1001;
    m_wstrb   = {4'hF, 4'(cyc)};
    s_rdata   = 32'hD000_0000 + cyc;
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
    cyc = cyc + 1;
  endtask

  task automatic drain();
    for (int i = 0; i < OUTST + 1 && on[0] > 0; i++) step(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  logic [7:0] glog;
  logic [7:0] flog;
  logic [7:0] dlog;
  logic [5:0] f2log;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      on[d] = 0;
      pend[d] = -1;
      ptr[d] = 0;
      merr[d] = 1'b0;
    end

    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0);

    // both channels request every cycle
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("lit_rst_cnt", 0, 64'(l_cnt[0]), 64'd0);
    chk("lit_rst_err", 0, 64'(l_err[0]), 64'd0);
    glog = 8'(l_aok[0]);
    flog = 8'(l_aok[1]);
    dlog = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, 1'b1, 1'b1);
      glog = {glog[5:0], l_aok[0]};
      flog = {flog[5:0], l_aok[1]};
      dlog = {dlog[5:0], l_dok[0]};
    end
    step(1'b0, 2'b00, 1'b1, 1'b1);
    dlog = {dlog[5:0], l_dok[0]};
    chk("lit_rr_grants", 0, 64'(glog), 64'h66);
    chk("lit_rr_resp", 0, 64'(dlog), 64'h66);
    chk("lit_fp_grants", 1, 64'(flog), 64'h55);

    // fixed priority yields to ch1 only when ch0 idle
    step(1'b0, 2'b11, 1'b1, 1'b0);
    f2log = 6'(l_aok[1]);
    step(1'b0, 2'b10, 1'b1, 1'b1);
    f2log = {f2log[3:0], l_aok[1]};
    step(1'b0, 2'b11, 1'b1, 1'b1);
    f2log = {f2log[3:0], l_aok[1]};
    chk("lit_fp_seq", 1, 64'(f2log), 64'h19);
    drain();

    // ch1 stalled and locked while ch0 also requests
    step(1'b0, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0);
      chk("lit_lock_addr", 1, 64'(l_saddr[1][31:28]), 64'hB);
      chk("lit_lock_aok", 0, 64'(l_aok[0]), 64'd0);
    end
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("lit_lock_accept", 0, 64'(l_aok[0]), 64'h2);
    chk("lit_lock_accept", 1, 64'(l_aok[1]), 64'h2);
    drain();

    // fill to OUTST, no bypass on a same-cycle pop
    for (int i = 0; i < OUTST; i++) step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    chk("lit_full_cnt", 0, 64'(l_cnt[0]), 64'd4);
    chk("lit_full_sreq", 0, 64'(l_sreq[0]), 64'd0);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    chk("lit_full_pop_sreq", 0, 64'(l_sreq[0]), 64'd0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    chk("lit_after_pop_cnt", 0, 64'(l_cnt[0]), 64'd3);
    chk("lit_after_pop_aok", 0, 64'(l_aok[0]), 64'h1);

    // push and pop together, then pointer wrap
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("lit_pushpop_cnt", 0, 64'(l_cnt[0]), 64'd2);
    for (int i = 0; i < 9; i++) step(1'b0, 2'b11, 1'b1, 1'b1);
    drain();

    // stray response, reset mid-transaction, late response
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("lit_err_clear", 0, 64'(l_err[0]), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("lit_stray_dok", 0, 64'(l_dok[0]), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("lit_stray_err", 0, 64'(l_err[0]), 64'd1);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("lit_reset_cnt", 0, 64'(l_cnt[0]), 64'd0);
    chk("lit_reset_err", 0, 64'(l_err[0]), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("lit_late_dok", 0, 64'(l_dok[0]), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("lit_late_err", 0, 64'(l_err[0]), 64'd1);
    step(1'b1, 2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
